div_pwm_mc: RTL and testbench

Multi-channel programmable clock divider / PWM generator on an Avalon-MM slave. Next generation of the single-channel divider.
- CH_NUM independent channels, each with its own period register; per-channel duty register when compiled in.
- Shadowed reload at the period boundary, so register writes cause no glitches.
- Entirely in the csi_clk domain; outputs drive timing strobes and slow clocks to board pins through conduit ports.

---
 rtl/div_pwm_pkg.sv | 38 +++
 rtl/div_pwm_mc_chan.sv | 82 ++++++++
 rtl/div_pwm_mc.sv | 119 +++++++++++
 tb/tb_div_pwm_mc.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pwm_pkg.sv
// div_pwm_pkg: shared register map constants and address decode for div_pwm_mc.
// Optional feature macro: DIV_PWM_DUTY_EN (adds per-channel duty registers / PWM mode).
package div_pwm_pkg;

  localparam int CTRL_OFS   = 0;
  localparam int STATUS_OFS = 1;
  localparam int CH_BASE    = 2;
  localparam int CH_STRIDE  = 2;

  // Which per-channel register a channel-window address selects
  typedef enum logic {
    FIELD_PERIOD = 1'b0,
    FIELD_DUTY   = 1'b1
  } field_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
    field_t     field;
  } chan_sel_t;

  // Map a word address onto a channel index and register field; hit=0 outside the channel window
  function automatic chan_sel_t decode_chan(input int addr, input int ch_num);
    chan_sel_t sel;
    int        rel;
    sel.hit   = 1'b0;
    sel.idx   = 3'd0;
    sel.field = FIELD_PERIOD;
    rel       = addr - CH_BASE;
    if (rel >= 0 && rel < CH_STRIDE * ch_num) begin
      sel.hit   = 1'b1;
      sel.idx   = 3'(rel / CH_STRIDE);
      sel.field = ((rel % CH_STRIDE) == 1) ? FIELD_DUTY : FIELD_PERIOD;
    end
    return sel;
  endfunction

endpackage

// File: rtl/div_pwm_mc_chan.sv
// div_pwm_chan: one divider/PWM channel with programmed registers, active shadows,
// counter and registered output. Optional feature macro: DIV_PWM_DUTY_EN
// (defined: PWM out = cnt < duty; undefined: output toggles at every wrap).
module div_pwm_chan
  import div_pwm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             csi_clk,
  input  logic             csi_reset,
  input  logic             enable,
  input  logic             wr_period,
  input  logic [CNT_W-1:0] wdata,
`ifdef DIV_PWM_DUTY_EN
  input  logic             wr_duty,
  output logic [CNT_W-1:0] duty,
`endif
  output logic [CNT_W-1:0] period,
  output logic             clk_out
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_act;
`ifdef DIV_PWM_DUTY_EN
  logic [CNT_W-1:0] duty_act;
`endif

  // Programmed period register; the counter only sees it through the shadow
  always_ff @(posedge csi_clk or posedge csi_reset) begin
    if (csi_reset) begin
      period <= '0;
    end else if (wr_period) begin
      period <= wdata;
    end
  end

`ifdef DIV_PWM_DUTY_EN
  // Programmed duty register; loaded into the shadow only at a wrap or while disabled
  always_ff @(posedge csi_clk or posedge csi_reset) begin
    if (csi_reset) begin
      duty <= '0;
    end else if (wr_duty) begin
      duty <= wdata;
    end
  end
`endif

  // Counter, shadow reload at the wrap, and the registered output
  always_ff @(posedge csi_clk or posedge csi_reset) begin
    if (csi_reset) begin
      cnt        <= '0;
      period_act <= '0;
`ifdef DIV_PWM_DUTY_EN
      duty_act   <= '0;
`endif
      clk_out    <= 1'b0;
    end else if (!enable) begin
      cnt        <= '0;
      clk_out    <= 1'b0;
      period_act <= period;
`ifdef DIV_PWM_DUTY_EN
      duty_act   <= duty;
`endif
    end else begin
`ifdef DIV_PWM_DUTY_EN
      clk_out <= (cnt < duty_act);
`endif
      if (cnt == period_act) begin
        cnt        <= '0;
        period_act <= period;
`ifdef DIV_PWM_DUTY_EN
        duty_act   <= duty;
`else
        clk_out    <= ~clk_out;
`endif
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_pwm_mc.sv
// div_pwm_mc: multi-channel clock divider / PWM generator behind an Avalon-MM slave.
// Holds CTRL, address decode and the registered read mux; channels live in div_pwm_chan.
// Optional feature macro: DIV_PWM_DUTY_EN (per-channel DUTY registers and PWM output).
module div_pwm_mc
  import div_pwm_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 4
) (
  input  logic              csi_clk,
  input  logic              csi_reset,
  input  logic              avs_chipselect,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic [CH_NUM-1:0] coe_clk_out
);

  logic [CH_NUM-1:0]            ctrl;
  logic [CH_NUM-1:0][CNT_W-1:0] period_q;
  logic [CH_NUM-1:0]            wr_period;
`ifdef DIV_PWM_DUTY_EN
  logic [CH_NUM-1:0][CNT_W-1:0] duty_q;
  logic [CH_NUM-1:0]            wr_duty;
`endif
  logic                         wr_en;
  logic                         rd_en;
  int                           addr_int;
  chan_sel_t                    sel;
  logic [31:0]                  rd_next;

  assign wr_en    = avs_chipselect & avs_write;
  assign rd_en    = avs_chipselect & avs_read;
  assign addr_int = int'(avs_address);
  assign sel      = decode_chan(addr_int, CH_NUM);

  // Per-channel write strobes from the decoded address
  always_comb begin
    wr_period = '0;
`ifdef DIV_PWM_DUTY_EN
    wr_duty   = '0;
`endif
    for (int i = 0; i < CH_NUM; i++) begin
      if (wr_en && sel.hit && sel.idx == 3'(i)) begin
        if (sel.field == FIELD_PERIOD) begin
          wr_period[i] = 1'b1;
        end
`ifdef DIV_PWM_DUTY_EN
        else begin
          wr_duty[i] = 1'b1;
        end
`endif
      end
    end
  end

  // CTRL register: one enable bit per channel
  always_ff @(posedge csi_clk or posedge csi_reset) begin
    if (csi_reset) begin
      ctrl <= '0;
    end else if (wr_en && addr_int == CTRL_OFS) begin
      ctrl <= avs_writedata[CH_NUM-1:0];
    end
  end

  // Read mux: zero-extended register contents, unmapped addresses return 0
  always_comb begin
    rd_next = '0;
    if (addr_int == CTRL_OFS) begin
      rd_next[CH_NUM-1:0] = ctrl;
    end else if (addr_int == STATUS_OFS) begin
      rd_next[CH_NUM-1:0] = coe_clk_out;
    end else if (sel.hit) begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (sel.idx == 3'(i)) begin
          if (sel.field == FIELD_PERIOD) begin
            rd_next[CNT_W-1:0] = period_q[i];
          end
`ifdef DIV_PWM_DUTY_EN
          else begin
            rd_next[CNT_W-1:0] = duty_q[i];
          end
`endif
        end
      end
    end
  end

  // Registered read data, held until the next read
  always_ff @(posedge csi_clk or posedge csi_reset) begin
    if (csi_reset) begin
      avs_readdata <= '0;
    end else if (rd_en) begin
      avs_readdata <= rd_next;
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
    div_pwm_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .csi_clk  (csi_clk),
      .csi_reset(csi_reset),
      .enable   (ctrl[g]),
      .wr_period(wr_period[g]),
      .wdata    (avs_writedata[CNT_W-1:0]),
`ifdef DIV_PWM_DUTY_EN
      .wr_duty  (wr_duty[g]),
      .duty     (duty_q[g]),
`endif
      .period   (period_q[g]),
      .clk_out  (coe_clk_out[g])
    );
  end

endmodule

// File: tb/tb_div_pwm_mc.sv
// tb_div_pwm_mc: directed self-checking bench for div_pwm_mc (CH_NUM=4, CNT_W=8).
// Expectations follow DIV_PWM_DUTY_EN when the macro is defined for the build.
module tb_div_pwm_mc;

  localparam int CH_NUM = 4;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = 4;

  logic              csi_clk;
  logic              csi_reset;
  logic              avs_chipselect;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic              avs_read;
  logic [31:0]       avs_readdata;
  logic [CH_NUM-1:0] coe_clk_out;

  int          n_cmp;
  int          n_bad;
  logic [31:0] rd_val;
  logic [15:0] exp_vec;
  logic        e0;
  logic        e2;

  div_pwm_mc #(
    .CH_NUM(CH_NUM),
    .CNT_W (CNT_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .csi_clk       (csi_clk),
    .csi_reset     (csi_reset),
    .avs_chipselect(avs_chipselect),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .coe_clk_out   (coe_clk_out)
  );

  // 10 ns system clock
  initial begin
    csi_clk = 1'b0;
    forever #5 csi_clk = ~csi_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge csi_clk);
    #1;
  endtask

  task automatic writeReg(input int addr, input logic [31:0] data);
    avs_chipselect = 1'b1;
    avs_write      = 1'b1;
    avs_address    = ADDR_W'(addr);
    avs_writedata  = data;
    tick();
    avs_chipselect = 1'b0;
    avs_write      = 1'b0;
  endtask

  task automatic readReg(input int addr, output logic [31:0] data);
    avs_chipselect = 1'b1;
    avs_read       = 1'b1;
    avs_address    = ADDR_W'(addr);
    tick();
    data           = avs_readdata;
    avs_chipselect = 1'b0;
    avs_read       = 1'b0;
  endtask

  task automatic applyReset();
    csi_reset = 1'b1;
    tick();
    tick();
    csi_reset = 1'b0;
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    csi_reset      = 1'b1;
    avs_chipselect = 1'b0;
    avs_address    = '0;
    avs_write      = 1'b0;
    avs_writedata  = '0;
    avs_read       = 1'b0;

    // Power-on reset
    tick();
    checkOutput("por_out", 32'(coe_clk_out), 32'h0);
    checkOutput("por_rd", avs_readdata, 32'h0);
    tick();
    csi_reset = 1'b0;
    readReg(0, rd_val);
    checkOutput("por_ctrl", rd_val, 32'h0);

    // Main output waveform
`ifdef DIV_PWM_DUTY_EN
    writeReg(4, 32'd9);
    writeReg(5, 32'd3);
    writeReg(0, 32'h2);
    for (int k = 1; k <= 20; k++) begin
      tick();
      checkOutput($sformatf("pwm_k%0d", k), 32'(coe_clk_out[1]), 32'(((k - 1) % 10) < 3));
    end
    writeReg(5, 32'd0);
    repeat (12) tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput($sformatf("pwm_d0_%0d", k), 32'(coe_clk_out[1]), 32'h0);
    end
    writeReg(5, 32'd12);
    repeat (12) tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput($sformatf("pwm_d12_%0d", k), 32'(coe_clk_out[1]), 32'h1);
    end
`else
    writeReg(2, 32'd3);
    writeReg(0, 32'h1);
    avs_chipselect = 1'b1;
    avs_read       = 1'b1;
    avs_address    = ADDR_W'(1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      checkOutput($sformatf("tog_k%0d", k), 32'(coe_clk_out[0]), 32'((k / 4) % 2));
      checkOutput($sformatf("tog_stat_k%0d", k), avs_readdata, 32'(((k - 1) / 4) % 2));
    end
    avs_chipselect = 1'b0;
    avs_read       = 1'b0;
`endif
    applyReset();

    // Shadowed reload: P 7 -> 2 written while cnt==3
`ifdef DIV_PWM_DUTY_EN
    writeReg(3, 32'd2);
    exp_vec = 16'hDB03;
`else
    exp_vec = 16'hE380;
`endif
    writeReg(2, 32'd7);
    writeReg(0, 32'h1);
    for (int k = 1; k <= 16; k++) begin
      if (k == 4) begin
        avs_chipselect = 1'b1;
        avs_write      = 1'b1;
        avs_address    = ADDR_W'(2);
        avs_writedata  = 32'd2;
      end
      tick();
      avs_chipselect = 1'b0;
      avs_write      = 1'b0;
      checkOutput($sformatf("reload_k%0d", k), 32'(coe_clk_out[0]), 32'(exp_vec[k-1]));
    end
    readReg(2, rd_val);
    checkOutput("reload_p", rd_val, 32'd2);
    applyReset();

    // Channel independence: ch0 P=1, ch2 P=4, then ch0 disabled
`ifdef DIV_PWM_DUTY_EN
    writeReg(3, 32'd1);
    writeReg(7, 32'd2);
`endif
    writeReg(2, 32'd1);
    writeReg(6, 32'd4);
    writeReg(0, 32'h5);
    for (int k = 1; k <= 20; k++) begin
      if (k == 11) begin
        avs_chipselect = 1'b1;
        avs_write      = 1'b1;
        avs_address    = ADDR_W'(0);
        avs_writedata  = 32'h4;
      end
      tick();
      avs_chipselect = 1'b0;
      avs_write      = 1'b0;
`ifdef DIV_PWM_DUTY_EN
      e0 = (k >= 12) ? 1'b0 : (((k - 1) % 2) < 1);
      e2 = ((k - 1) % 5) < 2;
`else
      e0 = (k >= 12) ? 1'b0 : 1'((k / 2) % 2);
      e2 = 1'((k / 5) % 2);
`endif
      checkOutput($sformatf("indep_k%0d", k), 32'(coe_clk_out), 32'({1'b0, e2, 1'b0, e0}));
    end
    applyReset();

    // Register access, truncation to CNT_W bits and unmapped addresses
    for (int a = 2; a <= 9; a++) writeReg(a, 32'hFFFF_FFFF);
    writeReg(12, 32'hFFFF_FFFF);
    writeReg(0, 32'hFFFF_FFFF);
    readReg(0, rd_val);
    checkOutput("reg_ctrl", rd_val, 32'hF);
    for (int a = 2; a <= 9; a++) begin
      readReg(a, rd_val);
`ifdef DIV_PWM_DUTY_EN
      checkOutput($sformatf("reg_a%0d", a), rd_val, 32'hFF);
`else
      checkOutput($sformatf("reg_a%0d", a), rd_val, (a % 2 == 0) ? 32'hFF : 32'h0);
`endif
    end
    readReg(1, rd_val);
`ifdef DIV_PWM_DUTY_EN
    checkOutput("reg_status", rd_val, 32'hF);
`else
    checkOutput("reg_status", rd_val, 32'h0);
`endif
    readReg(4, rd_val);
    checkOutput("reg_p1", rd_val, 32'hFF);
    avs_chipselect = 1'b1;
    avs_read       = 1'b1;
    avs_address    = ADDR_W'(12);
    @(negedge csi_clk);
    checkOutput("lat_before_edge", avs_readdata, 32'hFF);
    tick();
    checkOutput("lat_unmapped", avs_readdata, 32'h0);
    avs_address = ADDR_W'(6);
    tick();
    avs_chipselect = 1'b0;
    avs_read       = 1'b0;
    repeat (3) tick();
    checkOutput("rd_hold", avs_readdata, 32'hFF);
    applyReset();

    // Asynchronous reset in the middle of a period
    writeReg(3, 32'd4);
    writeReg(2, 32'd5);
    writeReg(0, 32'h1);
    repeat (6) tick();
    readReg(2, rd_val);
    checkOutput("pre_rst_p", rd_val, 32'd5);
    checkOutput("pre_rst_out", 32'(coe_clk_out[0]), 32'h1);
    #3;
    csi_reset = 1'b1;
    #1;
    checkOutput("rst_out", 32'(coe_clk_out), 32'h0);
    checkOutput("rst_rd", avs_readdata, 32'h0);
    tick();
    csi_reset = 1'b0;
    readReg(0, rd_val);
    checkOutput("rst_ctrl", rd_val, 32'h0);
    readReg(2, rd_val);
    checkOutput("rst_p0", rd_val, 32'h0);
    repeat (8) tick();
    checkOutput("rst_out_after", 32'(coe_clk_out), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
